// File: rtl/pc_fetch_unit.sv
// PC and instruction-fetch stage: fetches from a fixed-latency synchronous imem,
// holds the instruction until retirement, then loads next_pc from branch control.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] next_pc,
   input  logic        instr_done,
   input  logic        halt_req,
   input  logic [31:0] imem_rdata,
   output logic [31:0] imem_addr,
   output logic        imem_en,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        halted,
   output logic        misaligned,
   output logic [31:0] retired_count
);

   // state   | meaning
   // FETCH   | issue one imem read at pc (or divert to HALT if halt pending)
   // WAIT    | count imem latency; capture imem_rdata when count hits MEM_LATENCY
   // EXEC    | present instr until instr_done retires it and loads next_pc
   // HALT    | stopped; only rst leaves
   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [2:0] LAT = 3'(MEM_LATENCY);

   state_t     state;
   logic [2:0] wait_cnt;
   logic       halt_pend;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_FETCH;
         pc            <= RESET_PC;
         instr         <= 32'h0;
         instr_valid   <= 1'b0;
         halted        <= 1'b0;
         misaligned    <= 1'b0;
         retired_count <= 32'h0;
         halt_pend     <= 1'b0;
         wait_cnt      <= 3'd0;
      end else begin
         if (halt_req)
            halt_pend <= 1'b1;
         case (state)
            S_FETCH: begin
               if (halt_pend) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
               end else begin
                  state    <= S_WAIT;
                  wait_cnt <= 3'd1;
               end
            end
            S_WAIT: begin
               if (wait_cnt == LAT) begin
                  instr       <= imem_rdata;
                  instr_valid <= 1'b1;
                  state       <= S_EXEC;
               end else begin
                  wait_cnt <= wait_cnt + 3'd1;
               end
            end
            S_EXEC: begin
               if (instr_done) begin
                  retired_count <= retired_count + 32'd1;
                  instr_valid   <= 1'b0;
                  pc            <= next_pc;
                  // a misaligned target is still architecturally loaded, but never fetched
                  if (next_pc[1:0] != 2'b00) begin
                     misaligned <= 1'b1;
                     halted     <= 1'b1;
                     state      <= S_HALT;
                  end else if (halt_pend || halt_req) begin
                     halted <= 1'b1;
                     state  <= S_HALT;
                  end else begin
                     state <= S_FETCH;
                  end
               end
            end
            S_HALT: begin
               halted <= 1'b1;
            end
            default: begin
               state <= S_HALT;
            end
         endcase
      end
   end

   // the read strobe is gated by rst so no read is issued while the unit is held in reset
   assign imem_en   = (state == S_FETCH) && !halt_pend && !rst;
   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a cycle table on a latency-1 instance and
// hand sequences on a latency-3 instance reset to the top of the address space.
module tb_pc_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0000_000A;
         32'h4:   return 32'h0000_000B;
         32'h8:   return 32'h0000_000C;
         default: return a ^ 32'h1357_0000;
      endcase
   endfunction

   // ---------------- latency-1 instance ----------------
   logic        rst1, done1, halt1;
   logic [31:0] npc1, rdata1, addr1, pc1, pcp1, instr1, cnt1;
   logic        en1, iv1, hlt1, mis1;

   pc_fetch_unit #(.RESET_PC(32'h0), .MEM_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst1), .next_pc(npc1), .instr_done(done1), .halt_req(halt1),
      .imem_rdata(rdata1), .imem_addr(addr1), .imem_en(en1), .pc(pc1), .pc_plus4(pcp1),
      .instr(instr1), .instr_valid(iv1), .halted(hlt1), .misaligned(mis1),
      .retired_count(cnt1)
   );

   logic        m1_v = 1'b0;
   logic [31:0] m1_a = 32'h0;
   always @(posedge clk) begin
      m1_v <= en1;
      m1_a <= addr1;
   end
   assign rdata1 = m1_v ? mem_word(m1_a) : 32'hDEAD_BEEF;

   // ---------------- latency-3 instance ----------------
   logic        rst3, done3, halt3;
   logic [31:0] npc3, rdata3, addr3, pc3, pcp3, instr3, cnt3;
   logic        en3, iv3, hlt3, mis3;

   pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .MEM_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst3), .next_pc(npc3), .instr_done(done3), .halt_req(halt3),
      .imem_rdata(rdata3), .imem_addr(addr3), .imem_en(en3), .pc(pc3), .pc_plus4(pcp3),
      .instr(instr3), .instr_valid(iv3), .halted(hlt3), .misaligned(mis3),
      .retired_count(cnt3)
   );

   logic [2:0]  m3_v = 3'b000;
   logic [31:0] m3_a [3];
   always @(posedge clk) begin
      m3_v    <= {m3_v[1:0], en3};
      m3_a[0] <= addr3;
      m3_a[1] <= m3_a[0];
      m3_a[2] <= m3_a[1];
   end
   assign rdata3 = m3_v[2] ? mem_word(m3_a[2]) : 32'hDEAD_BEEF;

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst, done, halt;
      logic [31:0] npc;
      logic        en;
      logic [31:0] pc;
      logic        iv;
      logic [31:0] instr;
      logic        hlt, mis;
      logic [31:0] cnt;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic r, input logic d, input logic h, input logic [31:0] n,
                      input logic e, input logic [31:0] p, input logic v, input logic [31:0] i,
                      input logic hl, input logic m, input logic [31:0] c);
      vec_t x;
      x.rst = r; x.done = d; x.halt = h; x.npc = n;
      x.en = e; x.pc = p; x.iv = v; x.instr = i; x.hlt = hl; x.mis = m; x.cnt = c;
      tv.push_back(x);
   endtask

   localparam logic [31:0] IA  = 32'hA;
   localparam logic [31:0] IB  = 32'hB;
   localparam logic [31:0] IC  = 32'hC;
   localparam logic [31:0] I40 = 32'h1357_0040;
   localparam logic [31:0] I44 = 32'h1357_0044;

   initial begin
      rst1 = 1'b1; done1 = 1'b0; halt1 = 1'b0; npc1 = 32'h0;
      rst3 = 1'b1; done3 = 1'b0; halt3 = 1'b0; npc3 = 32'h0;

      //  rst d h npc        en pc      iv instr hl m cnt
      add(1, 0,0, 32'h0,     0, 32'h0,  0, 0,   0, 0, 0);   // reset state
      add(0, 0,0, 32'h0,     1, 32'h0,  0, 0,   0, 0, 0);   // FETCH 0
      add(0, 1,0, 32'h99,    0, 32'h0,  0, 0,   0, 0, 0);   // WAIT, done ignored
      add(0, 1,0, 32'h4,     0, 32'h0,  1, IA,  0, 0, 0);
      add(0, 0,0, 32'h0,     1, 32'h4,  0, IA,  0, 0, 1);
      add(0, 0,0, 32'h0,     0, 32'h4,  0, IA,  0, 0, 1);
      add(0, 1,0, 32'h8,     0, 32'h4,  1, IB,  0, 0, 1);
      add(0, 0,0, 32'h0,     1, 32'h8,  0, IB,  0, 0, 2);
      add(0, 0,0, 32'h0,     0, 32'h8,  0, IB,  0, 0, 2);
      add(0, 1,0, 32'h40,    0, 32'h8,  1, IC,  0, 0, 2);   // branch
      add(0, 0,0, 32'h0,     1, 32'h40, 0, IC,  0, 0, 3);
      add(0, 0,0, 32'h0,     0, 32'h40, 0, IC,  0, 0, 3);
      for (int k = 0; k < 5; k++)                             // execute stall
         add(0, 0,0, 32'h0,  0, 32'h40, 1, I40, 0, 0, 3);
      add(0, 1,0, 32'h44,    0, 32'h40, 1, I40, 0, 0, 3);
      add(0, 0,0, 32'h0,     1, 32'h44, 0, I40, 0, 0, 4);
      add(0, 0,1, 32'h0,     0, 32'h44, 0, I40, 0, 0, 4);   // halt pulse in WAIT
      add(0, 1,0, 32'h48,    0, 32'h44, 1, I44, 0, 0, 4);
      add(0, 0,0, 32'h0,     0, 32'h48, 0, I44, 1, 0, 5);
      add(0, 1,0, 32'h100,   0, 32'h48, 0, I44, 1, 0, 5);   // done ignored in HALT
      add(0, 0,0, 32'h0,     0, 32'h48, 0, I44, 1, 0, 5);
      add(1, 0,0, 32'h0,     0, 32'h48, 0, I44, 1, 0, 5);
      add(0, 0,0, 32'h0,     1, 32'h0,  0, 0,   0, 0, 0);
      add(0, 0,0, 32'h0,     0, 32'h0,  0, 0,   0, 0, 0);
      add(0, 1,0, 32'h42,    0, 32'h0,  1, IA,  0, 0, 0);   // misaligned target
      add(0, 0,0, 32'h0,     0, 32'h42, 0, IA,  1, 1, 1);
      add(0, 0,0, 32'h0,     0, 32'h42, 0, IA,  1, 1, 1);
      add(1, 0,0, 32'h0,     0, 32'h42, 0, IA,  1, 1, 1);
      add(0, 0,0, 32'h0,     1, 32'h0,  0, 0,   0, 0, 0);
      add(0, 0,0, 32'h0,     0, 32'h0,  0, 0,   0, 0, 0);
      add(1, 1,0, 32'h4,     0, 32'h0,  1, IA,  0, 0, 0);   // reset beats retire
      add(0, 0,0, 32'h0,     1, 32'h0,  0, 0,   0, 0, 0);
      add(0, 0,0, 32'h0,     0, 32'h0,  0, 0,   0, 0, 0);
      add(0, 1,1, 32'h4,     0, 32'h0,  1, IA,  0, 0, 0);   // halt with retire
      add(0, 0,0, 32'h0,     0, 32'h4,  0, IA,  1, 0, 1);
      add(0, 0,0, 32'h0,     0, 32'h4,  0, IA,  1, 0, 1);

      repeat (2) @(posedge clk);

      for (int i = 0; i < tv.size(); i++) begin
         @(negedge clk);
         rst1 = tv[i].rst; done1 = tv[i].done; halt1 = tv[i].halt; npc1 = tv[i].npc;
         #1;
         chk($sformatf("v%0d_imem_en", i),  32'(en1),   32'(tv[i].en));
         chk($sformatf("v%0d_pc", i),       pc1,        tv[i].pc);
         chk($sformatf("v%0d_imem_addr", i), addr1,     tv[i].pc);
         chk($sformatf("v%0d_pc_plus4", i), pcp1,       tv[i].pc + 32'd4);
         chk($sformatf("v%0d_valid", i),    32'(iv1),   32'(tv[i].iv));
         chk($sformatf("v%0d_instr", i),    instr1,     tv[i].instr);
         chk($sformatf("v%0d_halted", i),   32'(hlt1),  32'(tv[i].hlt));
         chk($sformatf("v%0d_misaligned", i), 32'(mis1), 32'(tv[i].mis));
         chk($sformatf("v%0d_retired", i),  cnt1,       tv[i].cnt);
      end
      @(negedge clk);
      rst1 = 1'b1; done1 = 1'b0; halt1 = 1'b0;

      // latency 3, PC wrap
      @(negedge clk);
      rst3 = 1'b0;
      #1;
      chk("l3_fetch_en", 32'(en3), 32'd1);
      chk("l3_fetch_pc", pc3, 32'hFFFF_FFFC);
      chk("l3_pc_plus4_wrap", pcp3, 32'h0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk); #1;
         chk($sformatf("l3_wait%0d_valid", k), 32'(iv3), 32'd0);
         chk($sformatf("l3_wait%0d_en", k), 32'(en3), 32'd0);
      end
      @(negedge clk);
      done3 = 1'b1; npc3 = 32'h0;
      #1;
      chk("l3_valid_rise", 32'(iv3), 32'd1);
      chk("l3_instr", instr3, mem_word(32'hFFFF_FFFC));
      @(negedge clk);
      done3 = 1'b0;
      #1;
      chk("l3_fetch2_en", 32'(en3), 32'd1);
      chk("l3_fetch2_pc", pc3, 32'h0);
      chk("l3_fetch2_plus4", pcp3, 32'h4);
      chk("l3_retired", cnt3, 32'd1);
      @(negedge clk); #1;
      chk("l3_w1_en", 32'(en3), 32'd0);
      @(negedge clk);
      rst3 = 1'b1;                               // reset in second WAIT cycle
      #1;
      @(negedge clk);
      rst3 = 1'b0;
      #1;
      chk("l3_rst_valid", 32'(iv3), 32'd0);
      chk("l3_rst_instr", instr3, 32'h0);
      chk("l3_rst_retired", cnt3, 32'h0);
      chk("l3_rst_halted", 32'(hlt3), 32'd0);
      chk("l3_refetch_pc", pc3, 32'hFFFF_FFFC);
      chk("l3_refetch_en", 32'(en3), 32'd1);
      repeat (3) begin
         @(negedge clk); #1;
         chk("l3_refetch_wait_valid", 32'(iv3), 32'd0);
      end
      @(negedge clk); #1;
      chk("l3_refetch_valid", 32'(iv3), 32'd1);
      chk("l3_refetch_instr", instr3, mem_word(32'hFFFF_FFFC));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch stage of the KGP miniRISC core. Holds the architectural PC and fetches the instruction at that PC from a synchronous instruction memory with fixed read latency. Presents the instruction to decode/execute, and on retirement loads the `next_pc` chosen by the branch-control logic. Also tracks retired instructions and handles halt and misaligned-target faults.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC after reset; must be word-aligned.
- `MEM_LATENCY`, default 1, imem read latency in cycles; legal range 1..4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `next_pc`  in  32  target PC from branch control; sampled only on retirement.
- `instr_done`  in  1  execute has finished the presented instruction and `next_pc` is valid.
- `halt_req`  in  1  request to stop fetching; latched.
- `imem_rdata`  in  32  instruction memory read data.
- `imem_addr`  out  32  instruction memory address; always equals `pc`.
- `imem_en`  out  1  instruction memory read enable.
- `pc`  out  32  current PC.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32, fed to branch control.
- `instr`  out  32  fetched instruction, registered.
- `instr_valid`  out  1  `instr` is valid and awaiting `instr_done`.
- `halted`  out  1  unit is in HALT.
- `misaligned`  out  1  sticky flag: a retirement supplied `next_pc[1:0] != 0`.
- `retired_count`  out  32  instructions retired; wraps modulo 2^32.

## Operation
- States are FETCH, WAIT, EXEC and HALT.
- **Reset (`rst`=1 at an edge):**
  - state <= FETCH; `pc` <= `RESET_PC`; `instr` <= 0.
  - `instr_valid`, `imem_en`, `halted`, `misaligned`, `retired_count` and halt-pending all <= 0.
  - The wait counter clears.
- **FETCH:**
  - `imem_en`=1 for exactly this one cycle.
  - Go to WAIT, with wait counter <= 1.
  - Exception: if halt-pending is set, `imem_en`=0 and the next state is HALT.
- **WAIT:**
  - `imem_en`=0.
  - While the counter < `MEM_LATENCY`, the counter increments.
  - When the counter == `MEM_LATENCY`:
    - `imem_rdata` is valid in this cycle.
    - At the edge, `instr` <= `imem_rdata` and `instr_valid` <= 1.
    - Go to EXEC.
- **EXEC:**
  - `instr` and `pc` are held stable.
  - `instr_valid`=1 until the edge on which `instr_done`=1 (retirement).
  - On retirement:
    - `retired_count` increments.
    - `instr_valid` <= 0.
    - `pc` <= `next_pc`.
    - If `next_pc[1:0] != 0`: `misaligned` <= 1, `pc` still loads `next_pc`, next state is HALT.
    - Otherwise, if halt-pending or `halt_req` is high this cycle, next state is HALT.
    - Otherwise, next state is FETCH.
- **HALT:**
  - `halted`=1; `imem_en`=0; `instr_valid`=0.
  - `pc` is frozen.
  - Left only by `rst`.
- **Ignored inputs:**
  - `halt_req` sets halt-pending in any state.
  - `instr_done` outside EXEC is ignored; no count, no PC change.
- **Arithmetic:**
  - `pc_plus4` is combinational from `pc`; 32'hFFFF_FFFC + 4 = 0.
  - `retired_count` 32'hFFFF_FFFF + 1 = 0.

## Timing
- With fetch in cycle t:
  - Data is sampled at the end of cycle t+`MEM_LATENCY`.
  - `instr_valid` rises in cycle t+`MEM_LATENCY`+1.
- Minimum per-instruction period is `MEM_LATENCY`+2 cycles, when `instr_done` arrives in the first EXEC cycle.
  - `MEM_LATENCY`=1 gives 3 cycles/instruction.
- First FETCH is the first cycle with `rst`=0.
- **Reset mid-WAIT or mid-EXEC:**
  - The in-flight read is discarded.
  - `instr_valid` is 0 in the cycle after the reset edge.
  - Fetch restarts at `RESET_PC`.
- **`rst` and `instr_done` in the same cycle:** reset wins; no retirement is counted.
- **`halt_req` and `instr_done` in the same EXEC cycle:** the instruction retires and is counted, `pc` loads `next_pc`, and the unit enters HALT.

## Test plan
- **Reset then sequential run.**
  - Stimulus: `RESET_PC`=0, `MEM_LATENCY`=1, imem[0..2]=0xA,0xB,0xC; `instr_done` on the first EXEC cycle with `next_pc`=`pc_plus4`.
  - Required: `imem_en` pulses every 3 cycles at 0,4,8; `instr` = 0xA,0xB,0xC; `retired_count`=3.
- **Branch target.**
  - Stimulus: on the first retire, `next_pc`=0x40.
  - Required: the next `imem_addr`=0x40 in the FETCH cycle, and `pc_plus4`=0x44.
- **Execute stall.**
  - Stimulus: hold `instr_done`=0 for 5 EXEC cycles.
  - Required: `instr_valid`, `instr` and `pc` are constant; `imem_en` stays 0; the count does not change.
- **Halt.**
  - Stimulus: pulse `halt_req` during WAIT.
  - Required: the current instruction still reaches EXEC and retires; then `halted`=1, no further `imem_en`, and `retired_count` increments by exactly 1.
- **Misaligned target.**
  - Stimulus: retire with `next_pc`=0x42.
  - Required: `misaligned`=1, `halted`=1, `pc`=0x42, no fetch of 0x42.
- **Latency and wrap.**
  - Stimulus: `MEM_LATENCY`=3, `RESET_PC`=32'hFFFF_FFFC.
  - Required: `instr_valid` rises 4 cycles after the `imem_en` pulse; `pc_plus4`=0.
  - Stimulus: `rst` asserted in the second WAIT cycle.
  - Required: outputs return to their reset values and a fresh fetch of `RESET_PC` follows.
